// File: rtl/mips_mem.sv
// mips_mem: memory-access stage of a MIPS I pipeline.
// Passes ALU results through to write-back, performs aligned byte/half/word
// loads and stores over a request/acknowledge bus, aligns and extends load
// data, and raises a one-cycle address-error pulse for misaligned accesses.
//
// Handshakes:
//   Upstream: a result transfers on a rising clock edge where
//     in_valid & in_ready are both 1. in_ready depends combinationally on
//     bus_ack, so a new op can be taken in the same cycle a transaction
//     completes.
//   Bus: bus_req is held with bus_we/bus_addr/bus_be/bus_wdata stable until
//     a cycle with bus_ack = 1. bus_ack while no request is outstanding is
//     ignored.
//
// Write-back ordering: a read completing in the same cycle that a
// pass-through op is accepted produces two results for one write-back port.
// The older (load) result goes out first and the pass-through result waits
// one cycle in a single-entry skid register. One entry is enough because a
// load acceptance always leaves a cycle with no new write-back, which drains
// the skid before the next read can complete.
module mips_mem #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_D,
  input  logic [31:0] in_T,
  input  logic [4:0]  in_rd,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        ae,
  output logic        ae_store,
  output logic [31:0] ae_va,
  output logic        state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t state;

  // Context of the outstanding transaction, needed to align read data.
  logic [4:0] p_rd;
  logic [1:0] p_size;
  logic       p_uns;
  logic [1:0] p_off;

  // Single-entry write-back skid.
  logic        skid_v;
  logic [4:0]  skid_rd;
  logic [31:0] skid_data;

  logic        ack_now;
  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic        pt_wb;
  logic        ld_wb;
  logic [3:0]  be_le;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [1:0]  lane;
  logic        hsel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        first_v;
  logic [4:0]  first_rd;
  logic [31:0] first_data;
  logic        second_v;
  logic [4:0]  second_rd;
  logic [31:0] second_data;

  assign ack_now    = (state == BUS) & bus_ack;
  assign in_ready   = (state == IDLE) | ack_now;
  assign accept     = in_valid & in_ready;
  assign is_mem     = (in_kind == 2'b01) | (in_kind == 2'b10);
  assign misaligned = ((in_size == 2'b01) & in_D[0]) |
                      (in_size[1] & (in_D[1:0] != 2'b00));
  assign pt_wb      = accept & ~is_mem & (in_rd != 5'd0);
  assign ld_wb      = ack_now & ~bus_we & (p_rd != 5'd0);
  assign state_dbg  = state;

  // Byte enables and replicated write data for the op being accepted.
  always_comb begin
    be_le     = 4'b1111;
    wdata_new = in_T;
    case (in_size)
      2'b00: begin
        be_le     = 4'b0001 << in_D[1:0];
        wdata_new = {4{in_T[7:0]}};
      end
      2'b01: begin
        be_le     = in_D[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{in_T[15:0]}};
      end
      default: begin
        be_le     = 4'b1111;
        wdata_new = in_T;
      end
    endcase
    be_new = BIG_ENDIAN ? {be_le[0], be_le[1], be_le[2], be_le[3]} : be_le;
  end

  // Lane selection and sign/zero extension of returning read data.
  always_comb begin
    lane    = BIG_ENDIAN ? ~p_off : p_off;
    hsel    = BIG_ENDIAN ? ~p_off[1] : p_off[1];
    ld_byte = bus_rdata[{lane, 3'b000} +: 8];
    ld_half = hsel ? bus_rdata[31:16] : bus_rdata[15:0];
    case (p_size)
      2'b00:   ld_data = {{24{ld_byte[7] & ~p_uns}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~p_uns}}, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  // Order this cycle's write-back candidates: skid, then load, then pass-through.
  always_comb begin
    first_v     = 1'b0;
    first_rd    = 5'd0;
    first_data  = 32'd0;
    second_v    = 1'b0;
    second_rd   = 5'd0;
    second_data = 32'd0;
    if (skid_v) begin
      first_v    = 1'b1;
      first_rd   = skid_rd;
      first_data = skid_data;
      if (ld_wb) begin
        second_v    = 1'b1;
        second_rd   = p_rd;
        second_data = ld_data;
      end else if (pt_wb) begin
        second_v    = 1'b1;
        second_rd   = in_rd;
        second_data = in_D;
      end
    end else if (ld_wb) begin
      first_v    = 1'b1;
      first_rd   = p_rd;
      first_data = ld_data;
      if (pt_wb) begin
        second_v    = 1'b1;
        second_rd   = in_rd;
        second_data = in_D;
      end
    end else if (pt_wb) begin
      first_v    = 1'b1;
      first_rd   = in_rd;
      first_data = in_D;
    end
  end

  // Control FSM: launches bus transactions and flags address errors.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 30'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      ae        <= 1'b0;
      ae_store  <= 1'b0;
      ae_va     <= 32'd0;
      p_rd      <= 5'd0;
      p_size    <= 2'd0;
      p_uns     <= 1'b0;
      p_off     <= 2'd0;
    end else begin
      ae <= 1'b0;
      if (ack_now) begin
        state   <= IDLE;
        bus_req <= 1'b0;
      end
      if (accept && is_mem) begin
        if (misaligned) begin
          ae       <= 1'b1;
          ae_store <= (in_kind == 2'b10);
          ae_va    <= in_D;
          state    <= IDLE;
          bus_req  <= 1'b0;
        end else begin
          state     <= BUS;
          bus_req   <= 1'b1;
          bus_we    <= (in_kind == 2'b10);
          bus_addr  <= in_D[31:2];
          bus_be    <= be_new;
          bus_wdata <= wdata_new;
          p_rd      <= in_rd;
          p_size    <= in_size;
          p_uns     <= in_unsigned;
          p_off     <= in_D[1:0];
        end
      end
    end
  end

  // Write-back port and skid register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      skid_v    <= 1'b0;
      skid_rd   <= 5'd0;
      skid_data <= 32'd0;
    end else begin
      wb_valid <= first_v;
      if (first_v) begin
        wb_rd   <= first_rd;
        wb_data <= first_data;
      end
      skid_v <= second_v;
      if (second_v) begin
        skid_rd   <= second_rd;
        skid_data <= second_data;
      end
    end
  end

endmodule
